// File: rtl/rs_multi_wakeup_if.sv
// Issue, CDB snoop, dispatch and status signals of the multi-wakeup reservation station.
// The slave modport is the station itself; master is whoever drives issue/CDB and sinks dispatch.
interface rs_multi_wakeup_if #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int OP_W    = 6
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     rdy;
    logic                     flush;

    logic                     in_valid;
    logic                     in_ready;
    logic [OP_W-1:0]          in_op;
    logic [TAG_W-1:0]         in_Qj;
    logic [TAG_W-1:0]         in_Qk;
    logic [31:0]              in_Vj;
    logic [31:0]              in_Vk;
    logic                     in_Rj;
    logic                     in_Rk;
    logic [31:0]              in_imm;
    logic [31:0]              in_pc;
    logic [TAG_W-1:0]         in_tag;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*32-1:0]    cdb_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [OP_W-1:0]          out_op;
    logic [31:0]              out_Vj;
    logic [31:0]              out_Vk;
    logic [31:0]              out_imm;
    logic [31:0]              out_pc;
    logic [TAG_W-1:0]         out_tag;

    logic [CW-1:0]            count;
    logic                     full;

    modport master (
        output rdy, flush,
        output in_valid, in_op, in_Qj, in_Qk, in_Vj, in_Vk, in_Rj, in_Rk, in_imm, in_pc, in_tag,
        input  in_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  out_valid, out_op, out_Vj, out_Vk, out_imm, out_pc, out_tag,
        output out_ready,
        input  count, full
    );

    modport slave (
        input  rdy, flush,
        input  in_valid, in_op, in_Qj, in_Qk, in_Vj, in_Vk, in_Rj, in_Rk, in_imm, in_pc, in_tag,
        output in_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output out_valid, out_op, out_Vj, out_Vk, out_imm, out_pc, out_tag,
        input  out_ready,
        output count, full
    );
endinterface

// File: rtl/rs_multi_wakeup.sv
// Reservation station: snoops NUM_CDB result buses for operand wakeup (with bypass at issue)
// and dispatches the oldest ready entry into a registered valid/ready output stage.
module rs_multi_wakeup #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int OP_W    = 6
) (
    input logic              clk,
    input logic              rst,
    rs_multi_wakeup_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic             rj;
        logic             rk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [IW-1:0]    age;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      imm;
        logic [31:0]      pc;
    } out_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } snoop_t;

    // Lowest-index matching channel wins: scan high to low so the last write is the lowest.
    function automatic snoop_t snoop(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       valid,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*32-1:0]    data
    );
        snoop_t r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (valid[c] && tags[c*TAG_W +: TAG_W] == tag) begin
                r.hit  = 1'b1;
                r.data = data[c*32 +: 32];
            end
        end
        return r;
    endfunction

    logic [DEPTH-1:0] busy_q, busy_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic             out_valid_q, out_valid_d;
    out_t             out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;

    snoop_t           wake_j [DEPTH];
    snoop_t           wake_k [DEPTH];
    snoop_t           byp_j, byp_k;

    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    sel_age;
    logic             free_found;
    logic [IW-1:0]    free_idx;
    logic             out_free;
    logic             accept;
    logic             depart;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake_j[i] = snoop(ent_q[i].qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            wake_k[i] = snoop(ent_q[i].qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
        byp_j = snoop(bus.in_Qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        byp_k = snoop(bus.in_Qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    // Oldest ready entry; ages of busy entries are unique, so the minimum is unambiguous.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && ent_q[i].rj && ent_q[i].rk && (!sel_found || ent_q[i].age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_age   = ent_q[i].age;
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign out_free = !out_valid_q || bus.out_ready;
    assign depart   = bus.rdy && out_free && sel_found;
    assign accept   = bus.rdy && bus.in_valid && free_found;

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned and infers a latch.
    always_comb begin
        busy_d      = busy_q;
        ent_d       = ent_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i]) begin
                if (!ent_q[i].rj && wake_j[i].hit) begin
                    ent_d[i].rj = 1'b1;
                    ent_d[i].vj = wake_j[i].data;
                end
                if (!ent_q[i].rk && wake_k[i].hit) begin
                    ent_d[i].rk = 1'b1;
                    ent_d[i].vk = wake_k[i].data;
                end
                if (depart && ent_q[i].age > sel_age)
                    ent_d[i].age = ent_q[i].age - 1'b1;
            end
        end

        if (out_free) begin
            out_valid_d = sel_found;
            if (sel_found) begin
                busy_d[sel_idx] = 1'b0;
                out_d.op  = ent_q[sel_idx].op;
                out_d.tag = ent_q[sel_idx].tag;
                out_d.vj  = ent_q[sel_idx].vj;
                out_d.vk  = ent_q[sel_idx].vk;
                out_d.imm = ent_q[sel_idx].imm;
                out_d.pc  = ent_q[sel_idx].pc;
            end
        end

        // The free slot was not busy, so it never collides with the wakeup/dispatch updates above.
        if (accept) begin
            busy_d[free_idx]     = 1'b1;
            ent_d[free_idx].op   = bus.in_op;
            ent_d[free_idx].tag  = bus.in_tag;
            ent_d[free_idx].qj   = bus.in_Qj;
            ent_d[free_idx].qk   = bus.in_Qk;
            ent_d[free_idx].rj   = bus.in_Rj || byp_j.hit;
            ent_d[free_idx].rk   = bus.in_Rk || byp_k.hit;
            ent_d[free_idx].vj   = (!bus.in_Rj && byp_j.hit) ? byp_j.data : bus.in_Vj;
            ent_d[free_idx].vk   = (!bus.in_Rk && byp_k.hit) ? byp_k.data : bus.in_Vk;
            ent_d[free_idx].imm  = bus.in_imm;
            ent_d[free_idx].pc   = bus.in_pc;
            ent_d[free_idx].age  = IW'(count_q - CW'(depart));
        end

        count_d = count_q + CW'(accept) - CW'(depart);
        full_d  = (count_d == CW'(DEPTH));

        if (bus.flush) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
            count_d     = '0;
            full_d      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
        end else if (bus.rdy) begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            count_q     <= count_d;
            full_q      <= full_d;
        end
    end

    // NOTE: entry payload is not reset; a slot is only ever read while its busy bit is set.
    always_ff @(posedge clk) begin
        if (bus.rdy)
            ent_q <= ent_d;
    end

    assign bus.in_ready  = free_found;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_q.op;
    assign bus.out_tag   = out_q.tag;
    assign bus.out_Vj    = out_q.vj;
    assign bus.out_Vk    = out_q.vk;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_pc    = out_q.pc;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
endmodule

// File: tb/tb_rs_multi_wakeup.sv
// Directed bench for rs_multi_wakeup: a vector table for dispatch order, wakeup and bypass,
// plus hand sequences for hold, back-pressure, full and flush.
module tb_rs_multi_wakeup;
    localparam int DEPTH   = 16;
    localparam int TAG_W   = 4;
    localparam int NUM_CDB = 2;
    localparam int OP_W    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    rs_multi_wakeup_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .OP_W(OP_W)) bus ();

    rs_multi_wakeup #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  tag;
        logic        rj;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic        rk;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic [1:0]  cv;
        logic [3:0]  ct0;
        logic [31:0] cd0;
        logic [3:0]  ct1;
        logic [31:0] cd1;
        logic        ordy;
        logic        e_ov;
        logic [3:0]  e_tag;
        logic [31:0] e_vj;
        logic [31:0] e_vk;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // op/imm/pc are derived from the tag so every dispatched field is checkable.
    task automatic issue(input logic iv, input logic [3:0] tag, input logic rj, input logic [3:0] qj,
                         input logic [31:0] vj, input logic rk, input logic [3:0] qk, input logic [31:0] vk);
        bus.in_valid = iv;
        bus.in_tag   = tag;
        bus.in_op    = 6'(tag) + 6'd1;
        bus.in_Rj    = rj;
        bus.in_Qj    = qj;
        bus.in_Vj    = vj;
        bus.in_Rk    = rk;
        bus.in_Qk    = qk;
        bus.in_Vk    = vk;
        bus.in_imm   = 32'h1000 + 32'(tag);
        bus.in_pc    = 32'h4000 + 32'(tag);
    endtask

    task automatic cdb(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] d0,
                       input logic [3:0] t1, input logic [31:0] d1);
        bus.cdb_valid = v;
        bus.cdb_tag   = {t1, t0};
        bus.cdb_data  = {d1, d0};
    endtask

    task automatic idle();
        issue(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic check_state(input string name, input logic ov, input int cnt);
        check({name, " out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({name, " count"},     32'(bus.count),     32'(cnt));
        check({name, " full"},      32'(bus.full),      32'(cnt == DEPTH));
        check({name, " in_ready"},  32'(bus.in_ready),  32'(cnt != DEPTH));
    endtask

    task automatic check_out(input string name, input logic [3:0] tag, input logic [31:0] vj, input logic [31:0] vk);
        check({name, " out_tag"}, 32'(bus.out_tag), 32'(tag));
        check({name, " out_Vj"},  bus.out_Vj,       vj);
        check({name, " out_Vk"},  bus.out_Vk,       vk);
        check({name, " out_op"},  32'(bus.out_op),  32'(6'(tag) + 6'd1));
        check({name, " out_imm"}, bus.out_imm,      32'h1000 + 32'(tag));
        check({name, " out_pc"},  bus.out_pc,       32'h4000 + 32'(tag));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Table columns: iv tag rj qj vj rk qk vk | cv ct0 cd0 ct1 cd1 | ordy | e_ov e_tag e_vj e_vk e_cnt
        tbl.push_back(vec_t'{1, 3, 1, 0, 32'h5,  1, 0, 32'h7,  2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 1, 3, 32'h5, 32'h7, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        // Age order: A (entry 0) waits on tag 2; C (entry 2) is older than D (entry 1).
        tbl.push_back(vec_t'{1, 8, 0, 2, 0,      1, 0, 32'h11, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{1, 9, 1, 0, 32'h21, 1, 0, 32'h22, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2});
        tbl.push_back(vec_t'{1, 10, 1, 0, 32'h31, 1, 0, 32'h32, 2'b00, 0, 0, 0, 0, 1, 1, 9, 32'h21, 32'h22, 2});
        tbl.push_back(vec_t'{1, 11, 1, 0, 32'h41, 1, 0, 32'h42, 2'b00, 0, 0, 0, 0, 0, 1, 9, 32'h21, 32'h22, 3});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 1, 10, 32'h31, 32'h32, 2});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b11, 7, 32'hDEAD, 2, 32'hAA, 1, 1, 11, 32'h41, 32'h42, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 1, 8, 32'hAA, 32'h11, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        // Issue bypass on k, then bypass on both with the lowest channel winning.
        tbl.push_back(vec_t'{1, 6, 1, 0, 32'h51, 0, 6, 0,      2'b01, 6, 32'h1234, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 1, 6, 32'h51, 32'h1234, 0});
        tbl.push_back(vec_t'{1, 7, 0, 3, 0,      0, 3, 0,      2'b11, 3, 32'hC0, 3, 32'hC1, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 1, 7, 32'hC0, 32'hC0, 0});
        // Stale Qj on a ready operand must not recapture.
        tbl.push_back(vec_t'{1, 1, 1, 4, 32'h61, 0, 5, 0,      2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b11, 4, 32'hDEAD, 5, 32'h77, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 1, 1, 32'h61, 32'h77, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        // Wakeup of a waiting entry with both channels matching: channel 0 wins.
        tbl.push_back(vec_t'{1, 2, 0, 9, 0,      1, 0, 32'h99, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b11, 9, 32'hA0, 9, 32'hA1, 1, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 1, 2, 32'hA0, 32'h99, 0});
        tbl.push_back(vec_t'{0, 0, 0, 0, 0,      0, 0, 0,      2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});

        // Reset state
        do_reset();
        check_state("reset", 1'b0, 0);
        check("reset out_tag", 32'(bus.out_tag), 32'd0);
        check("reset out_Vj", bus.out_Vj, 32'd0);

        // rdy low freezes everything, including a ready entry
        issue(1'b1, 4'd4, 1'b1, 4'd0, 32'h44, 1'b1, 4'd0, 32'h45);
        step();
        check_state("rdy pre", 1'b0, 1);
        idle();
        bus.rdy = 1'b0;
        repeat (2) begin
            step();
            check_state("rdy low", 1'b0, 1);
        end
        bus.rdy = 1'b1;
        step();
        check_state("rdy resume", 1'b1, 0);
        check_out("rdy resume", 4'd4, 32'h44, 32'h45);
        step();
        check_state("rdy drain", 1'b0, 0);

        // Table-driven vectors
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i].iv, tbl[i].tag, tbl[i].rj, tbl[i].qj, tbl[i].vj, tbl[i].rk, tbl[i].qk, tbl[i].vk);
            cdb(tbl[i].cv, tbl[i].ct0, tbl[i].cd0, tbl[i].ct1, tbl[i].cd1);
            bus.out_ready = tbl[i].ordy;
            step();
            check_state($sformatf("vec%0d", i), tbl[i].e_ov, int'(tbl[i].e_cnt));
            if (tbl[i].e_ov)
                check_out($sformatf("vec%0d", i), tbl[i].e_tag, tbl[i].e_vj, tbl[i].e_vk);
        end
        idle();

        // Back-pressure: first entry parks in the output stage, three wait behind it
        do_reset();
        bus.out_ready = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            issue(1'b1, 4'(t), 1'b1, 4'd0, 32'h100 + 32'(t), 1'b1, 4'd0, 32'h200 + 32'(t));
            step();
        end
        idle();
        for (int c = 0; c < 5; c++) begin
            step();
            check_state($sformatf("bp hold%0d", c), 1'b1, 3);
            check_out($sformatf("bp hold%0d", c), 4'd1, 32'h101, 32'h201);
        end
        bus.out_ready = 1'b1;
        for (int t = 2; t <= 4; t++) begin
            step();
            check_state($sformatf("bp drain%0d", t), 1'b1, 4 - t);
            check_out($sformatf("bp drain%0d", t), 4'(t), 32'h100 + 32'(t), 32'h200 + 32'(t));
        end
        step();
        check_state("bp empty", 1'b0, 0);

        // Full: 16 waiting entries, entry i waits on tag i
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 4'(i), 1'b0, 4'(i), 32'd0, 1'b1, 4'd0, 32'(i));
            step();
            check_state($sformatf("fill%0d", i), 1'b0, i + 1);
        end
        issue(1'b1, 4'd14, 1'b1, 4'd0, 32'hEE, 1'b1, 4'd0, 32'hEF);
        step();
        check_state("full drop", 1'b0, DEPTH);
        cdb(2'b01, 4'd5, 32'h55, 4'd0, 32'd0);
        step();
        check_state("full wake", 1'b0, DEPTH);
        idle();
        step();
        check_state("full depart", 1'b1, DEPTH - 1);
        check_out("full depart", 4'd5, 32'h55, 32'd5);
        step();
        check_state("full after", 1'b0, DEPTH - 1);

        // Flush with a stalled output, 8 busy entries, and a same-cycle issue and CDB match
        do_reset();
        bus.out_ready = 1'b0;
        issue(1'b1, 4'd12, 1'b1, 4'd0, 32'hC, 1'b1, 4'd0, 32'hD);
        step();
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 4'(i), 1'b0, 4'(i), 32'd0, 1'b1, 4'd0, 32'd0);
            step();
        end
        check_state("pre flush", 1'b1, 8);
        check_out("pre flush", 4'd12, 32'hC, 32'hD);
        bus.flush = 1'b1;
        issue(1'b1, 4'd13, 1'b1, 4'd0, 32'h13, 1'b1, 4'd0, 32'h14);
        cdb(2'b11, 4'd0, 32'h1, 4'd1, 32'h2);
        step();
        check_state("flush", 1'b0, 0);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        issue(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cdb(2'b11, 4'(2 * k), 32'h10, 4'(2 * k + 1), 32'h20);
            step();
            check_state($sformatf("post flush%0d", k), 1'b0, 0);
        end
        idle();
        step();
        check_state("post flush idle", 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rs_multi_wakeup.md
Name: rs_multi_wakeup

Overview:
- Parametrised next-generation reservation station for the out-of-order core; sits between issue/decode and the ALU.
- Holds up to DEPTH waiting instructions and snoops NUM_CDB broadcast buses for operand wakeup, including same-cycle bypass at issue.
- Dispatches the oldest ready entry, not the lowest index, over a valid/ready handshake to the ALU.
- Reports occupancy and supports full flush on rollback.

Parameters:
- DEPTH, 16, number of entries (power of two, ≥2)
- TAG_W, 4, ROB tag width
- NUM_CDB, 2, number of CDB broadcast channels snooped
- OP_W, 6, opcode width

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rdy  input  1  global enable; when low, all state holds
- flush  input  1  rollback; clears all entries and the output register
- in_valid  input  1  issue request
- in_ready  output  1  combinational; high when at least one entry is free
- in_op  input  OP_W  opcode
- in_Qj, in_Qk  input  TAG_W  producer tags
- in_Vj, in_Vk  input  32  operand values
- in_Rj, in_Rk  input  1  operand-ready flags
- in_imm, in_pc  input  32  immediate, pc
- in_tag  input  TAG_W  destination ROB tag
- cdb_valid  input  NUM_CDB  per-channel broadcast valid
- cdb_tag  input  NUM_CDB*TAG_W  channel c at bits [c*TAG_W +: TAG_W]
- cdb_data  input  NUM_CDB*32  channel c at bits [c*32 +: 32]
- out_valid  output  1  registered; dispatch to ALU
- out_ready  input  1  ALU accepts
- out_op  output  OP_W
- out_Vj, out_Vk, out_imm, out_pc  output  32
- out_tag  output  TAG_W
- count  output  $clog2(DEPTH)+1  registered occupancy
- full  output  1  registered, equal to (count==DEPTH)

Behaviour:
- Reset, or flush while rdy: every busy bit = 0; out_valid = 0; count = 0; full = 0. Other output data is don't-care, driven to 0 at reset. Flush overrides any issue, dispatch or wakeup in the same cycle.
- rdy low: no state changes. in_ready still reflects current occupancy.
- Issue accept:
  - Accept when in_valid & in_ready & rdy.
  - Write to the lowest-index free entry; visible next cycle.
  - An entry freed by dispatch in the same cycle is not reusable until the next cycle.
- Issue bypass: if in_Rj=0 and some cdb_valid[c] has cdb_tag[c]==in_Qj in the accept cycle, store Rj=1 and Vj=cdb_data[c]. Same rule for k.
- Wakeup:
  - Each rdy cycle, every busy entry with Rx=0 and Qx matching a valid channel captures the data and sets Rx=1.
  - If several channels match, the lowest channel index wins.
  - Both operands may wake in the same cycle.
- Age tracking:
  - Each entry has age in [0, DEPTH-1]; 0 is oldest.
  - On accept, the new entry's age = number of busy entries remaining after this cycle's departure.
  - When an entry departs, every busy entry with a larger age decrements by 1.
  - Ages of busy entries are always unique and contiguous from 0.
- Ready: Rj & Rk & busy, from registered state. An entry woken in cycle N is eligible for selection in cycle N+1.
- Dispatch:
  - The output register is free when out_valid=0 or out_ready=1.
  - If it is free and any entry is ready, select the ready entry with minimum age. Load its fields into the output register, set out_valid=1 and clear that busy bit.
  - If it is free and no entry is ready, out_valid becomes 0.
  - If out_valid=1 and out_ready=0, the output holds stable and no entry leaves.
- Latency: an issued instruction with both operands ready at issue gives out_valid two cycles after acceptance, assuming no older ready entry and no stall.
- count/full: next count = count + accept − depart. Simultaneous accept and depart leaves count unchanged.
- Full: in_ready=0; in_valid is ignored and no entry is overwritten.
- Tag match considers only the Q fields of not-ready operands. A stale Q on a ready operand never re-captures.

Test Plan:
- Reset then single issue: in_Rj=in_Rk=1, Vj=5, Vk=7, tag=3 accepted cycle 0 → out_valid=1 cycle 2 with out_Vj=5, out_Vk=7, out_tag=3; count goes 0→1→0.
- Age order: issue A (Qj=2, not ready), then B, C ready; broadcast tag 2 with data 0xAA on channel 1 → B dispatches, then C, then A with Vj=0xAA, even though A is in entry 0.
- Issue bypass: issue with in_Rk=0, in_Qk=6 while cdb_valid=2'b01, cdb_tag[0]=6, data 0x1234 → dispatched out_Vk=0x1234 with no further broadcast.
- Back-pressure: out_ready=0 for 5 cycles with 3 ready entries → out_* stable, count stays 3; release → one dispatch per cycle, count 3→2→1→0.
- Full: issue 16 unready entries → full=1, count=16, in_ready=0. Extra in_valid is dropped. Wake one and dispatch it → in_ready=1 the cycle after departure.
- Flush mid-operation: 8 busy entries, out_valid=1, flush=1 with simultaneous in_valid and CDB match → next cycle count=0, out_valid=0; no later dispatch of old entries.
